// File: rtl/ctrl_pkg.sv
// Shared definitions for the systolic-array phase sequencer.
// Phase encodings and the state-counter width helper.
package ctrl_pkg;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_LOAD  = 3'd1,
        PH_FEED  = 3'd2,
        PH_DRAIN = 3'd3,
        PH_DONE  = 3'd4
    } phase_e;

    // Width able to hold 0..3N+1 without wrap.
    function automatic int cnt_w(input int n);
        return $clog2(3 * n + 2);
    endfunction

endpackage

// File: rtl/ctrl_phase_sequencer_if.sv
// Control/status bundle between the sequencer and its host.
// The host drives start/abort/tile_count; the sequencer drives the rest.
interface ctrl_phase_sequencer_if #(
    parameter int N      = 32,
    parameter int TILE_W = 8
);
    localparam int CNT_W = ctrl_pkg::cnt_w(N);

    logic              start;
    logic              abort;
    logic [TILE_W-1:0] tile_count;
    logic [2:0]        phase;
    logic [CNT_W-1:0]  state_count;
    logic [TILE_W-1:0] tile_idx;
    logic              load_en;
    logic              feed_en;
    logic              drain_en;
    logic              busy;
    logic              done;

    modport master (
        output start, abort, tile_count,
        input  phase, state_count, tile_idx,
        input  load_en, feed_en, drain_en, busy, done
    );

    modport slave (
        input  start, abort, tile_count,
        output phase, state_count, tile_idx,
        output load_en, feed_en, drain_en, busy, done
    );

endinterface

// File: rtl/ctrl_bounded_counter.sv
// Up-counter with clear, increment and a terminal-value flag.
// Clear together with increment restarts the count at 1.
module ctrl_bounded_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] term,
    output logic [W-1:0] count,
    output logic         at_term
);
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_q;

    assign at_term = (count_q == term);
    assign count   = count_q;

    // Count register; saturates at term so it can never wrap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= inc ? ONE : '0;
        end else if (inc && !at_term) begin
            count_q <= count_q + ONE;
        end
    end

endmodule

// File: rtl/ctrl_phase_sequencer.sv
// Phase sequencer for an N x N systolic array: LOAD, FEED, DRAIN per tile.
// Tiles run back to back; a one-cycle DONE follows the last one.
module ctrl_phase_sequencer
    import ctrl_pkg::*;
#(
    parameter int N      = 32,
    parameter int TILE_W = 8
) (
    input logic                   clk,
    input logic                   rstn,
    ctrl_phase_sequencer_if.slave bus
);
    localparam int CNT_W = cnt_w(N);

    localparam logic [CNT_W-1:0]  END_LOAD  = CNT_W'(N);
    localparam logic [CNT_W-1:0]  END_FEED  = CNT_W'(2 * N);
    localparam logic [CNT_W-1:0]  END_TILE  = CNT_W'(3 * N + 1);
    localparam logic [TILE_W-1:0] TILE_ONE  = {{(TILE_W-1){1'b0}}, 1'b1};

    phase_e            phase_q, phase_d;
    logic [TILE_W-1:0] tiles_q, tiles_d;
    logic              load_q, feed_q, drain_q, busy_q, done_q;

    logic              sc_clr, sc_inc, sc_term;
    logic              ti_clr, ti_inc, ti_term;
    logic [CNT_W-1:0]  sc;
    logic [TILE_W-1:0] ti;
    logic [TILE_W-1:0] ti_last;

    assign ti_last = tiles_q - TILE_ONE;

    ctrl_bounded_counter #(.W(CNT_W)) u_state_cnt (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (sc_clr),
        .inc     (sc_inc),
        .term    (END_TILE),
        .count   (sc),
        .at_term (sc_term)
    );

    ctrl_bounded_counter #(.W(TILE_W)) u_tile_cnt (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (ti_clr),
        .inc     (ti_inc),
        .term    (ti_last),
        .count   (ti),
        .at_term (ti_term)
    );

    // Next phase and counter controls; abort overrides everything.
    always_comb begin
        phase_d = phase_q;
        tiles_d = tiles_q;
        sc_clr  = 1'b0;
        sc_inc  = 1'b0;
        ti_clr  = 1'b0;
        ti_inc  = 1'b0;
        if (bus.abort) begin
            phase_d = PH_IDLE;
            tiles_d = '0;
            sc_clr  = 1'b1;
            ti_clr  = 1'b1;
        end else begin
            unique case (phase_q)
                PH_IDLE: begin
                    if (bus.start) begin
                        phase_d = PH_LOAD;
                        sc_clr  = 1'b1;
                        sc_inc  = 1'b1;
                        ti_clr  = 1'b1;
                        tiles_d = (bus.tile_count == '0) ? TILE_ONE
                                                         : bus.tile_count;
                    end
                end
                PH_LOAD: begin
                    sc_inc = 1'b1;
                    if (sc == END_LOAD) phase_d = PH_FEED;
                end
                PH_FEED: begin
                    sc_inc = 1'b1;
                    if (sc == END_FEED) phase_d = PH_DRAIN;
                end
                PH_DRAIN: begin
                    if (!sc_term) begin
                        sc_inc = 1'b1;
                    end else if (ti_term) begin
                        phase_d = PH_DONE;
                        sc_clr  = 1'b1;
                        ti_clr  = 1'b1;
                    end else begin
                        phase_d = PH_LOAD;
                        sc_clr  = 1'b1;
                        sc_inc  = 1'b1;
                        ti_inc  = 1'b1;
                    end
                end
                PH_DONE: begin
                    phase_d = PH_IDLE;
                end
                default: begin
                    phase_d = PH_IDLE;
                    sc_clr  = 1'b1;
                    ti_clr  = 1'b1;
                end
            endcase
        end
    end

    // Phase, latched tile count and registered strobes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase_q <= PH_IDLE;
            tiles_q <= '0;
            load_q  <= 1'b0;
            feed_q  <= 1'b0;
            drain_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            tiles_q <= tiles_d;
            load_q  <= (phase_d == PH_LOAD);
            feed_q  <= (phase_d == PH_FEED);
            drain_q <= (phase_d == PH_DRAIN);
            busy_q  <= (phase_d == PH_LOAD) || (phase_d == PH_FEED) ||
                       (phase_d == PH_DRAIN);
            done_q  <= (phase_d == PH_DONE);
        end
    end

    assign bus.phase       = phase_q;
    assign bus.state_count = sc;
    assign bus.tile_idx    = ti;
    assign bus.load_en     = load_q;
    assign bus.feed_en     = feed_q;
    assign bus.drain_en    = drain_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule
